// File: rtl/seed_path_index_gen.sv
// seed_path_index_gen
//   For each of TAU challenged executions, reads the execution's i_star leaf
//   index and walks from that leaf towards the root of a heap-indexed seed
//   tree. At every level it emits the heap index of the sibling node. These
//   are the nodes whose seeds must be revealed.
//
// Ports
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : begin a run (sampled only while idle)
//   o_done            : one-cycle completion pulse
//   o_busy            : high whenever not idle
//   o_i_star_addr     : read address into the i_star store
//   o_i_star_rd_en    : read strobe; data returns on i_i_star one cycle later
//   i_i_star          : i_star byte for the addressed execution
//   o_node_idx        : heap index of the sibling node to reveal
//   o_exec            : execution index of the current beat
//   o_level           : tree depth of the current beat (D_HYPERCUBE .. 1)
//   o_valid, i_ready  : beat handshake
module seed_path_index_gen #(
    parameter string       PARAMETER_SET = "L1",
    parameter int unsigned TAU           = 17,
    parameter int unsigned D_HYPERCUBE   = 8,
    localparam int unsigned ExecW        = (TAU > 1) ? $clog2(TAU) : 1,
    localparam int unsigned NodeW        = D_HYPERCUBE + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_done,
    output logic             o_busy,
    output logic [ExecW-1:0] o_i_star_addr,
    output logic             o_i_star_rd_en,
    input  logic [7:0]       i_i_star,
    output logic [NodeW-1:0] o_node_idx,
    output logic [ExecW-1:0] o_exec,
    output logic [3:0]       o_level,
    output logic             o_valid,
    input  logic             i_ready
);

    // First leaf in heap order: 2**D - 1.
    localparam logic [NodeW-1:0] LeafBase = NodeW'((2 ** D_HYPERCUBE) - 1);
    localparam logic [ExecW-1:0] LastExec = ExecW'(TAU - 1);
    localparam logic [3:0]       TopLevel = 4'(D_HYPERCUBE);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StEmit,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [ExecW-1:0] exec_q, exec_d;
    logic [NodeW-1:0] node_q, node_d;
    logic [3:0]       level_q, level_d;

    logic [NodeW-1:0] sibling;
    logic [NodeW-1:0] parent;

    // Odd nodes are left children, so their sibling sits to the right.
    assign sibling = node_q[0] ? (node_q + 1'b1) : (node_q - 1'b1);
    assign parent  = (node_q - 1'b1) >> 1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            exec_q  <= '0;
            node_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            exec_q  <= exec_d;
            node_q  <= node_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        exec_d         = exec_q;
        node_d         = node_q;
        level_d        = level_q;
        o_done         = 1'b0;
        o_i_star_rd_en = 1'b0;
        o_valid        = 1'b0;
        o_node_idx     = '0;
        o_level        = '0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    exec_d  = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                o_i_star_rd_en = 1'b1;
                state_d        = StLatch;
            end
            StLatch: begin
                node_d  = LeafBase + NodeW'(i_i_star);
                level_d = TopLevel;
                state_d = StEmit;
            end
            StEmit: begin
                o_valid    = 1'b1;
                o_node_idx = sibling;
                o_level    = level_q;
                if (i_ready) begin
                    if (level_q > 4'd1) begin
                        node_d  = parent;
                        level_d = level_q - 4'd1;
                    end else if (exec_q == LastExec) begin
                        state_d = StDone;
                    end else begin
                        exec_d  = exec_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_busy        = (state_q != StIdle);
    assign o_exec        = exec_q;
    assign o_i_star_addr = exec_q;

endmodule

// File: tb/tb_seed_path_index_gen.sv
module tb_seed_path_index_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic       busy;
    logic [4:0] addr;
    logic       rd_en;
    logic [7:0] istar;
    logic [8:0] node;
    logic [4:0] oexec;
    logic [3:0] lvl;
    logic       valid;
    logic       ready;

    always #5 clk = ~clk;

    seed_path_index_gen #(
        .PARAMETER_SET("L1"),
        .TAU(17),
        .D_HYPERCUBE(8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .o_done        (done),
        .o_busy        (busy),
        .o_i_star_addr (addr),
        .o_i_star_rd_en(rd_en),
        .i_i_star      (istar),
        .o_node_idx    (node),
        .o_exec        (oexec),
        .o_level       (lvl),
        .o_valid       (valid),
        .i_ready       (ready)
    );

    // i_star store: registered read, data one cycle after the strobe.
    logic [7:0] mem [17];
    initial istar = 8'd0;
    always @(posedge clk) if (rd_en) istar <= mem[addr];

    int n_cmp = 0;
    int n_err = 0;

    int exp_node [136];
    int exp_exec [136];
    int exp_lvl  [136];
    int cap_node [136];

    int t0   [8] = '{256, 128, 64, 32, 16, 8, 4, 2};
    int t255 [8] = '{509, 253, 125, 61, 29, 13, 5, 1};
    int t5   [8] = '{259, 130, 63, 32, 16, 8, 4, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void build_model();
        int k = 0;
        for (int e = 0; e < 17; e++) begin
            int n = 255 + int'(mem[e]);
            for (int l = 8; l >= 1; l--) begin
                exp_node[k] = (n % 2 == 1) ? n + 1 : n - 1;
                exp_exec[k] = e;
                exp_lvl[k]  = l;
                k++;
                n = (n - 1) / 2;
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_addr"},  32'(addr),  0);
        check({tag, "_node"},  32'(node),  0);
        check({tag, "_exec"},  32'(oexec), 0);
        check({tag, "_level"}, 32'(lvl),   0);
    endtask

    // One full run; start_at > 0 re-pulses i_start at that cycle (must be ignored).
    task automatic run(input bit bp, input int start_at);
        int  beats    = 0;
        int  dones    = 0;
        int  done_cyc = -1;
        bit  pv       = 1'b0;
        bit  pr       = 1'b1;
        int  pn       = 0;
        int  pe       = 0;
        int  pl       = 0;
        build_model();
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            start = (c == start_at);
            if (pv && !pr) begin
                check("hold_valid", 32'(valid), 1);
                check("hold_node",  32'(node),  32'(pn));
                check("hold_exec",  32'(oexec), 32'(pe));
                check("hold_level", 32'(lvl),   32'(pl));
            end
            if (valid) begin
                if (beats < 136) begin
                    check("beat_node",  32'(node),  32'(exp_node[beats]));
                    check("beat_exec",  32'(oexec), 32'(exp_exec[beats]));
                    check("beat_level", 32'(lvl),   32'(exp_lvl[beats]));
                    cap_node[beats] = int'(node);
                end else begin
                    check("extra_beat", 32'(beats), 135);
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            pv = valid;
            pr = ready;
            pn = int'(node);
            pe = int'(oexec);
            pl = int'(lvl);
            if (valid && ready) beats++;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        ready = 1'b1;
        check("beat_count", 32'(beats), 136);
        check("done_pulses", 32'(dones), 1);
        if (!bp) check("done_cycle", 32'(done_cyc), 171);
        else     check("done_seen", 32'(done_cyc > 0), 1);
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic abort_run();
        int dones = 0;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid && oexec == 5'd7) break;
        end
        check("reach_exec7", 32'(valid && oexec == 5'd7), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_rst");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_no_done", 32'(dones), 0);
        check("rst_idle", 32'(busy), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 17; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        mem[0] = 8'd0;
        run(1'b0, 0);
        for (int i = 0; i < 8; i++) check("leaf0_path", 32'(cap_node[i]), 32'(t0[i]));

        mem[0] = 8'd255;
        run(1'b0, 0);
        for (int i = 0; i < 8; i++) check("leaf255_path", 32'(cap_node[i]), 32'(t255[i]));

        mem[0] = 8'd5;
        run(1'b0, 0);
        for (int i = 0; i < 8; i++) check("leaf5_path", 32'(cap_node[i]), 32'(t5[i]));

        for (int i = 0; i < 17; i++) mem[i] = 8'($urandom);
        run(1'b0, 0);

        for (int i = 0; i < 17; i++) mem[i] = 8'($urandom);
        run(1'b1, 0);

        // Cycle 50 falls inside the EMIT phase of exec 4.
        run(1'b0, 50);

        abort_run();
        run(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seed_path_index_gen.md
SEED_PATH_INDEX_GEN -- requirements
Module: seed_path_index_gen

Interface
REQ-001 SHALL have parameter PARAMETER_SET, default "L1": security level selector.
REQ-002 SHALL have parameter TAU, default 17 for all sets: number of challenged executions.
REQ-003 SHALL have parameter D_HYPERCUBE, default 8: seed-tree depth; leaves = 2**D_HYPERCUBE.
REQ-004 SHALL have port i_clk, input, 1: sole clock, all logic rising-edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_start, input, 1: begin run; sampled only in IDLE.
REQ-007 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-008 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port o_i_star_addr, output, CLOG2(TAU): read address into the i_star store of expand_view_challenge.
REQ-010 SHALL have port o_i_star_rd_en, output, 1: read strobe to the i_star store.
REQ-011 SHALL have port i_i_star, input, 8: i_star byte; valid exactly one cycle after the strobe.
REQ-012 SHALL have port o_node_idx, output, D_HYPERCUBE+1: heap index of the sibling node to reveal.
REQ-013 SHALL have port o_exec, output, CLOG2(TAU): execution index of the current beat.
REQ-014 SHALL have port o_level, output, 4: tree depth of the current beat, D_HYPERCUBE down to 1.
REQ-015 SHALL have port o_valid, output, 1: beat valid.
REQ-016 SHALL have port i_ready, input, 1: consumer accepts beat.

Function
REQ-017 Tree SHALL use heap indexing: root 0, children of n at 2n+1 and 2n+2, leaf for i_star v at (2**D_HYPERCUBE - 1) + v.
REQ-018 Sibling of node n SHALL be n+1 when n is odd and n-1 when n is even; parent SHALL be (n-1)>>1.
REQ-019 FSM states SHALL be IDLE, READ, LATCH, EMIT, DONE.
REQ-020 IDLE: on i_start=1, clear exec counter to 0 and go to READ; otherwise stay.
REQ-021 READ: o_i_star_rd_en=1, o_i_star_addr=exec, single cycle, then LATCH.
REQ-022 LATCH: node register <= 255 + i_i_star (9-bit, no overflow), level <= D_HYPERCUBE, then EMIT.
REQ-023 EMIT: o_valid=1, o_node_idx=sibling(node), o_exec=exec, o_level=level; all held stable while i_ready=0.
REQ-024 On handshake (o_valid&i_ready) with level>1: node <= parent(node), level <= level-1, remain in EMIT.
REQ-025 On handshake with level=1: if exec=TAU-1 go to DONE, else exec <= exec+1 and go to READ.
REQ-026 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-027 o_i_star_rd_en SHALL be 0 outside READ; o_valid SHALL be 0 outside EMIT.
REQ-028 i_start asserted while busy SHALL be ignored.
REQ-029 With i_ready held high, o_done SHALL assert 10*TAU+1 cycles after the i_start cycle (171 for TAU=17); each execution costs 10 cycles.
REQ-030 Exactly TAU*D_HYPERCUBE beats (136) SHALL be emitted per run, in exec-ascending, level-descending order.

Reset
REQ-031 i_rst=1 SHALL force IDLE, exec=0, node=0, level=0 on the next edge, overriding all other inputs.
REQ-032 Reset values: o_done=0, o_busy=0, o_valid=0, o_i_star_rd_en=0, o_i_star_addr=0, o_node_idx=0, o_exec=0, o_level=0.
REQ-033 Reset mid-run SHALL abandon the run with no o_done pulse; a subsequent i_start SHALL restart from exec 0.

Verification
REQ-034 i_star[0]=0, i_ready=1 -> exec 0 beats 256,128,64,32,16,8,4,2 with o_level 8..1.
REQ-035 i_star[0]=255 -> beats 509,253,125,61,29,13,5,1; i_star[0]=5 -> 259,130,63,32,16,8,4,2.
REQ-036 17 random i_star values, i_ready=1 -> 136 beats matching reference model, o_done at cycle 171 after start, single pulse.
REQ-037 Random i_ready backpressure -> no beat lost or duplicated; o_node_idx/o_exec/o_level stable while o_valid&!i_ready.
REQ-038 i_rst pulsed during EMIT of exec 7 -> next cycle all outputs 0, no o_done; new i_start replays from exec 0 correctly.
REQ-039 i_start pulsed during EMIT -> ignored; beat sequence and o_done timing unchanged.
